dispense_arbiter: RTL and testbench

Round-robin controller that shares the vending machine's single dispense mechanism among four customer panels. Each panel raises a request with a 3-bit item code; the arbiter grants one panel at a time, starts the mechanism, supervises completion with a watchdog, and returns a per-panel done, reject or timeout pulse. It sits between the panel-side `food_seller` instances and the shared dispenser driver.

---
 rtl/dispense_arbiter_if.sv | 24 ++
 rtl/dispense_arbiter.sv | 137 +++++++++++++
 tb/tb_dispense_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dispense_arbiter_if.sv
// Handshake bundle between the dispense arbiter, the panel requesters and the
// shared dispense mechanism.
interface dispense_arbiter_if;
    logic [3:0]  req;
    logic [11:0] item_req;
    logic        disp_done;
    logic [3:0]  grant;
    logic [2:0]  disp_item;
    logic        disp_start;
    logic [3:0]  done;
    logic [3:0]  reject;
    logic [3:0]  timeout_err;
    logic        busy;

    modport slave (
        input  req, item_req, disp_done,
        output grant, disp_item, disp_start, done, reject, timeout_err, busy
    );

    modport master (
        output req, item_req, disp_done,
        input  grant, disp_item, disp_start, done, reject, timeout_err, busy
    );
endinterface

// File: rtl/dispense_arbiter.sv
// Round-robin owner of the single dispense mechanism shared by four panels,
// with a watchdog on mechanism completion. All outputs are registered.
module dispense_arbiter #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic                clk,
    input  logic                rst,
    dispense_arbiter_if.slave   arb
);

    typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, FINISH} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  win_q, win_d;
    logic [2:0]  item_q, item_d;
    logic [7:0]  wd_q, wd_d;
    logic [3:0]  grant_q, grant_d;
    logic [2:0]  disp_item_q, disp_item_d;
    logic        disp_start_q, disp_start_d;
    logic [3:0]  done_q, done_d;
    logic [3:0]  reject_q, reject_d;
    logic [3:0]  tmo_q, tmo_d;
    logic        busy_q, busy_d;

    logic [1:0]  rr_sel;
    logic [1:0]  rr_idx;
    logic [3:0]  win_onehot;

    // Scan from the farthest slot back to ptr so the nearest requester wins.
    always_comb begin
        rr_sel = ptr_q;
        rr_idx = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            rr_idx = ptr_q + 2'(i);
            if (arb.req[rr_idx]) rr_sel = rr_idx;
        end
    end

    assign win_onehot = 4'b0001 << win_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        item_d       = item_q;
        wd_d         = wd_q;
        grant_d      = grant_q;
        disp_item_d  = disp_item_q;
        disp_start_d = 1'b0;
        done_d       = 4'b0000;
        reject_d     = 4'b0000;
        tmo_d        = 4'b0000;
        case (state_q)
            IDLE: begin
                if (arb.req != 4'b0000) begin
                    win_d   = rr_sel;
                    item_d  = arb.item_req[4'(rr_sel) * 4'd3 +: 3];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                grant_d = win_onehot;
                if (item_q == 3'd0) begin
                    reject_d = win_onehot;
                    state_d  = FINISH;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                disp_start_d = 1'b1;
                disp_item_d  = item_q;
                wd_d         = 8'd0;
                state_d      = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 8'd1;
                // Completion takes precedence over a watchdog expiring the same cycle.
                if (arb.disp_done) begin
                    done_d  = win_onehot;
                    state_d = FINISH;
                end else if (wd_d == 8'(TIMEOUT)) begin
                    tmo_d   = win_onehot;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                grant_d     = 4'b0000;
                disp_item_d = 3'd0;
                ptr_d       = win_q + 2'd1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= 2'd0;
            win_q        <= 2'd0;
            item_q       <= 3'd0;
            wd_q         <= 8'd0;
            grant_q      <= 4'b0000;
            disp_item_q  <= 3'd0;
            disp_start_q <= 1'b0;
            done_q       <= 4'b0000;
            reject_q     <= 4'b0000;
            tmo_q        <= 4'b0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            item_q       <= item_d;
            wd_q         <= wd_d;
            grant_q      <= grant_d;
            disp_item_q  <= disp_item_d;
            disp_start_q <= disp_start_d;
            done_q       <= done_d;
            reject_q     <= reject_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
        end
    end

    assign arb.grant       = grant_q;
    assign arb.disp_item   = disp_item_q;
    assign arb.disp_start  = disp_start_q;
    assign arb.done        = done_q;
    assign arb.reject      = reject_q;
    assign arb.timeout_err = tmo_q;
    assign arb.busy        = busy_q;

endmodule

// File: tb/tb_dispense_arbiter.sv
// Directed bench for dispense_arbiter with a short watchdog so timeout and
// done/timeout tie cases are reachable in a few cycles.
module tb_dispense_arbiter;

    localparam int TMO = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dispense_arbiter_if arb ();

    dispense_arbiter #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the sampling edge. done_cycle = WAIT cycle on which the
    // mechanism reports done; 0 means it never does and the watchdog must fire.
    task automatic run_txn(input logic [3:0] exp_grant, input logic [2:0] exp_item,
                           input int done_cycle);
        int n;
        n = (done_cycle == 0) ? TMO : done_cycle;
        check("busy_in_grant", 32'(arb.busy), 32'd1);
        step();
        check("grant", 32'(arb.grant), 32'(exp_grant));
        check("no_reject", 32'(arb.reject), 32'd0);
        step();
        check("disp_start", 32'(arb.disp_start), 32'd1);
        check("disp_item", 32'(arb.disp_item), 32'(exp_item));
        for (int i = 1; i <= n; i++) begin
            if (i == n && done_cycle != 0) arb.disp_done = 1'b1;
            step();
            arb.disp_done = 1'b0;
            check("start_single", 32'(arb.disp_start), 32'd0);
            if (i < n) begin
                check("done_early", 32'(arb.done), 32'd0);
                check("tmo_early", 32'(arb.timeout_err), 32'd0);
            end else if (done_cycle != 0) begin
                check("done", 32'(arb.done), 32'(exp_grant));
                check("no_tmo", 32'(arb.timeout_err), 32'd0);
            end else begin
                check("tmo", 32'(arb.timeout_err), 32'(exp_grant));
                check("no_done", 32'(arb.done), 32'd0);
            end
        end
        step();
        check("grant_clear", 32'(arb.grant), 32'd0);
        check("busy_clear", 32'(arb.busy), 32'd0);
        check("item_clear", 32'(arb.disp_item), 32'd0);
        check("pulse_clear", 32'({arb.done, arb.reject, arb.timeout_err}), 32'd0);
        $display("txn grant=%b item=%0d done_cycle=%0d", exp_grant, exp_item, done_cycle);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        arb.req       = 4'b1111;
        arb.item_req  = {3'd1, 3'd1, 3'd1, 3'd1};
        arb.disp_done = 1'b0;

        // Reset held with all panels requesting.
        step();
        step();
        check("rst_grant", 32'(arb.grant), 32'd0);
        check("rst_busy", 32'(arb.busy), 32'd0);
        check("rst_outs", 32'({arb.disp_item, arb.disp_start, arb.done,
                               arb.reject, arb.timeout_err}), 32'd0);
        rst = 1'b1;

        // Fairness: 0,1,2,3,0 with immediate completion.
        step();
        run_txn(4'b0001, 3'd1, 1);
        step();
        run_txn(4'b0010, 3'd1, 1);
        step();
        run_txn(4'b0100, 3'd1, 1);
        step();
        run_txn(4'b1000, 3'd1, 1);
        step();
        run_txn(4'b0001, 3'd1, 1);
        arb.req = 4'b0000;

        // Single success on panel 2; inputs change after sampling.
        arb.req      = 4'b0100;
        arb.item_req = {3'd0, 3'd5, 3'd0, 3'd0};
        step();
        arb.req      = 4'b0000;
        arb.item_req = 12'd0;
        run_txn(4'b0100, 3'd5, 3);

        // Reject: panel 1 with item 0.
        arb.req = 4'b0010;
        step();
        arb.req = 4'b0000;
        step();
        check("rej_grant", 32'(arb.grant), 32'b0010);
        check("rej_pulse", 32'(arb.reject), 32'b0010);
        check("rej_start", 32'(arb.disp_start), 32'd0);
        step();
        check("rej_clear", 32'(arb.reject), 32'd0);
        check("rej_grant_clr", 32'(arb.grant), 32'd0);
        check("rej_busy", 32'(arb.busy), 32'd0);
        check("rej_start2", 32'(arb.disp_start), 32'd0);
        $display("txn grant=0010 rejected");

        // Pointer now at 2: all requesting, panel 2 must win.
        arb.req      = 4'b1111;
        arb.item_req = {3'd1, 3'd1, 3'd1, 3'd1};
        step();
        run_txn(4'b0100, 3'd1, 1);
        arb.req = 4'b0000;

        // Watchdog expiry on panel 0, then tie on panel 1.
        arb.req      = 4'b0001;
        arb.item_req = {3'd0, 3'd0, 3'd0, 3'd7};
        step();
        arb.req = 4'b0000;
        run_txn(4'b0001, 3'd7, 0);
        arb.req      = 4'b0010;
        arb.item_req = {3'd0, 3'd0, 3'd2, 3'd0};
        step();
        arb.req = 4'b0000;
        run_txn(4'b0010, 3'd2, TMO);

        // Reset in the middle of WAIT, then a stray completion.
        arb.req      = 4'b1000;
        arb.item_req = {3'd3, 3'd0, 3'd0, 3'd0};
        step();
        arb.req = 4'b0000;
        step();
        step();
        check("mid_start", 32'(arb.disp_start), 32'd1);
        step();
        #2;
        rst = 1'b0;
        #1;
        check("mid_grant", 32'(arb.grant), 32'd0);
        check("mid_busy", 32'(arb.busy), 32'd0);
        check("mid_item", 32'(arb.disp_item), 32'd0);
        #3;
        rst = 1'b1;
        arb.disp_done = 1'b1;
        step();
        arb.disp_done = 1'b0;
        check("stray_done", 32'(arb.done), 32'd0);
        check("stray_busy", 32'(arb.busy), 32'd0);
        step();
        check("stray_done2", 32'(arb.done), 32'd0);
        $display("txn mid-operation reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
